l2_cache_tag_array_clr: RTL and testbench

Parametrised single-port tag-array model for the L2 cache, succeeding the fixed 16×24 tag SRAM. It adds configurable width and depth, an optional per-group write mask, and a self-clearing sequence after reset that zeroes every entry. It also makes idle cycles side-effect free. It sits under the L2 controller, which must hold off tag lookups until `ready0` is high.

---
 rtl/l2_cache_tag_array_clr.sv | 133 +++++++++++++
 tb/tb_l2_cache_tag_array_clr.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/l2_cache_tag_array_clr.sv
// l2_cache_tag_array_clr: single-port L2 tag array with registered request,
// post-reset clear sweep and optional per-group write mask.
// Optional feature macro: L2_TAG_WMASK_EN (adds wmask0 and per-group writes).
module l2_cache_tag_array_clr #(
  parameter int                    DATA_WIDTH  = 24,
  parameter int                    ADDR_WIDTH  = 4,
  parameter int                    RAM_DEPTH   = 1 << ADDR_WIDTH,
  parameter int                    MASK_WIDTH  = 3,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  csb0,
  input  logic                  web0,
`ifdef L2_TAG_WMASK_EN
  input  logic [MASK_WIDTH-1:0] wmask0,
`endif
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  ready0
);

  // Group slicing only makes sense when the word splits evenly.
  if (DATA_WIDTH % MASK_WIDTH != 0) begin : g_bad_mask
    $error("DATA_WIDTH must be divisible by MASK_WIDTH");
  end

  typedef enum logic {CLEAR, READY} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  web0_reg_q, web0_reg_d;
  logic [ADDR_WIDTH-1:0] addr0_reg_q, addr0_reg_d;
  logic [DATA_WIDTH-1:0] din0_reg_q, din0_reg_d;
`ifdef L2_TAG_WMASK_EN
  logic [MASK_WIDTH-1:0] wmask0_reg_q, wmask0_reg_d;
`endif

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] wr_word;

`ifdef L2_TAG_WMASK_EN
  localparam int GW = DATA_WIDTH / MASK_WIDTH;
  // Merge enabled groups of the captured data over the current entry contents.
  for (genvar g = 0; g < MASK_WIDTH; g++) begin : g_merge
    assign wr_word[g*GW +: GW] = wmask0_reg_q[g] ? din0_reg_q[g*GW +: GW]
                                                 : mem_q[addr0_reg_q][g*GW +: GW];
  end
`else
  assign wr_word = din0_reg_q;
`endif

  // Next-state: clear sweep, request capture and the single memory write port.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    web0_reg_d  = web0_reg_q;
    addr0_reg_d = addr0_reg_q;
    din0_reg_d  = din0_reg_q;
`ifdef L2_TAG_WMASK_EN
    wmask0_reg_d = wmask0_reg_q;
`endif
    mem_we      = 1'b0;
    mem_waddr   = addr0_reg_q;
    mem_wdata   = wr_word;
    case (state_q)
      CLEAR: begin
        // Requests are ignored while sweeping; web0_reg stays high from reset.
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = CLEAR_VALUE;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == LAST) state_d = READY;
      end
      READY: begin
        // Commit the write captured on the previous edge.
        mem_we = !web0_reg_q;
        if (!csb0) begin
          web0_reg_d  = web0;
          addr0_reg_d = addr0;
          din0_reg_d  = din0;
`ifdef L2_TAG_WMASK_EN
          wmask0_reg_d = wmask0;
`endif
        end else begin
          // Deselect must never replay the last write.
          web0_reg_d = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
    // Reset edge drops any pending write.
    if (!rst_n) mem_we = 1'b0;
  end

  // Control and request registers with synchronous active-low reset.
  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      ptr_q       <= '0;
      web0_reg_q  <= 1'b1;
      addr0_reg_q <= '0;
      din0_reg_q  <= '0;
`ifdef L2_TAG_WMASK_EN
      wmask0_reg_q <= '1;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      web0_reg_q  <= web0_reg_d;
      addr0_reg_q <= addr0_reg_d;
      din0_reg_q  <= din0_reg_d;
`ifdef L2_TAG_WMASK_EN
      wmask0_reg_q <= wmask0_reg_d;
`endif
    end
  end

  // Storage array; contents are defined by the clear sweep, not by reset.
  always_ff @(posedge clk0) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign ready0 = (state_q == READY);
  assign dout0  = ready0 ? mem_q[addr0_reg_q] : '0;

endmodule

// File: tb/tb_l2_cache_tag_array_clr.sv
// Directed bench for l2_cache_tag_array_clr with default parameters.
module tb_l2_cache_tag_array_clr;

  logic        clk0 = 1'b0;
  logic        rst_n;
  logic        csb0;
  logic        web0;
`ifdef L2_TAG_WMASK_EN
  logic [2:0]  wmask0;
`endif
  logic [3:0]  addr0;
  logic [23:0] din0;
  logic [23:0] dout0;
  logic        ready0;

  int n_tot = 0;
  int n_bad = 0;

  l2_cache_tag_array_clr dut (
    .clk0   (clk0),
    .rst_n  (rst_n),
    .csb0   (csb0),
    .web0   (web0),
`ifdef L2_TAG_WMASK_EN
    .wmask0 (wmask0),
`endif
    .addr0  (addr0),
    .din0   (din0),
    .dout0  (dout0),
    .ready0 (ready0)
  );

  always #5 clk0 = ~clk0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic idle();
    csb0 = 1'b1;
    web0 = 1'b1;
`ifdef L2_TAG_WMASK_EN
    wmask0 = 3'b111;
`endif
  endtask

  task automatic do_write(input logic [3:0] a, input logic [23:0] d);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d;
    tick();
    idle();
  endtask

  task automatic do_read(input string tag, input logic [3:0] a, input logic [23:0] exp);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a;
    tick();
    idle();
    chk(tag, {8'h0, dout0}, {8'h0, exp});
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; addr0 = '0; din0 = '0;
    idle();
    repeat (3) tick();
    chk("rst_ready", {31'h0, ready0}, 32'h0);
    chk("rst_dout", {8'h0, dout0}, 32'h0);

    // Sweep with a write to addr 1 held on the inputs throughout.
    rst_n = 1'b1;
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd1; din0 = 24'h555555;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("sweep_ready_%0d", i), {31'h0, ready0}, {31'h0, 1'(i == 16)});
    end
    idle();
    chk("ready_dout", {8'h0, dout0}, 32'h0);
    do_read("clr_during_req", 4'd1, 24'h0);
    for (int a = 0; a < 16; a++)
      do_read($sformatf("clr_rd_%0d", a), 4'(a), 24'h0);

    // Write then read next cycle; data holds while deselected.
    do_write(4'd5, 24'hABCDEF);
    do_read("wr_rd_5", 4'd5, 24'hABCDEF);
    tick();
    chk("rd_hold_5", {8'h0, dout0}, 32'h00ABCDEF);

    // Back-to-back writes.
    do_write(4'd8, 24'h111111);
    do_write(4'd9, 24'h222222);
    do_read("b2b_8", 4'd8, 24'h111111);
    do_read("b2b_9", 4'd9, 24'h222222);

    // Idle safety: deselect must not replay, csb0=1 write is ignored.
    do_write(4'd2, 24'h000011);
    repeat (5) tick();
    chk("idle_dout_2", {8'h0, dout0}, 32'h00000011);
    csb0 = 1'b1; web0 = 1'b0; addr0 = 4'd2; din0 = 24'h000022;
    tick();
    idle();
    do_read("idle_rd_2", 4'd2, 24'h000011);

    // Masked write: only the middle group takes the new data.
    do_write(4'd3, 24'h123456);
    do_read("mask_pre_3", 4'd3, 24'h123456);
`ifdef L2_TAG_WMASK_EN
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd3; din0 = 24'hFFFFFF; wmask0 = 3'b010;
    tick();
    idle();
    do_read("mask_rd_3", 4'd3, 24'h12FF56);
`else
    do_write(4'd3, 24'hFFFFFF);
    do_read("full_rd_3", 4'd3, 24'hFFFFFF);
`endif

    // Reset on the edge after a write capture, then time the new sweep.
    csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd7; din0 = 24'hAAAAAA;
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    chk("midwr_ready", {31'h0, ready0}, 32'h0);
    chk("midwr_dout", {8'h0, dout0}, 32'h0);
    rst_n = 1'b1;
    cnt = 0;
    while (!ready0 && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("midwr_sweep_len", cnt, 32'd16);
    do_read("midwr_rd_7", 4'd7, 24'h0);
    do_read("midwr_rd_5", 4'd5, 24'h0);
    do_read("midwr_rd_2", 4'd2, 24'h0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
